obstacle_array_square_object: RTL
=================================

// Module: obstacle_array_square_object
// PURPOSE
//  Parametrised multi-slot successor of the single square obstacle: holds NUM_OBJECTS rectangles of
//  one size and detects, per VGA pixel, which (if any) covers the pixel. Positions are written by
//  game logic through a valid/ready port into shadow registers and committed atomically at
//  startOfFrame (no tearing). Adds per-slot blink-then-destroy mode for hit obstacles. Feeds the
//  bitmap/mux stage with offsets, draw request, colour and winning slot index.
// PARAMETERS
//  NUM_OBJECTS     4      number of obstacle slots (1..16)
//  OBJECT_WIDTH_X  64     rectangle width in pixels
//  OBJECT_HEIGHT_Y 64     rectangle height in pixels
//  OBJECT_COLOR    8'h5b  RGBout colour when drawing
//  BLINK_FRAMES    8      frames a hit slot blinks before auto-disable (1..255)
// PORTS
//  clk            in   1   system clock
//  resetN         in   1   asynchronous active-low reset
//  startOfFrame   in   1   one-cycle pulse at frame start
//  pixelX,pixelY  in   11s current VGA pixel (signed)
//  loadValid      in   1   slot write request
//  loadReady      out  1   write accepted when loadValid&&loadReady
//  loadIdx        in   4   target slot (ignored if >= NUM_OBJECTS)
//  loadTopLeftX/Y in   11s new top-left (signed, may be negative)
//  loadEnable     in   1   new enable value for slot
//  hitValid       in   1   one-cycle pulse: start blink on hitIdx
//  hitIdx         in   4   slot to blink
//  offsetX,offsetY out 11  pixel offset inside winning rectangle
//  drawingRequest out  1   pixel inside a visible rectangle
//  RGBout         out  8   OBJECT_COLOR or 8'hFF (transparent)
//  objectIdx      out  4   winning slot index (0 when no draw)
//  activeMask     out  NUM_OBJECTS  committed enable per slot
// BEHAVIOUR
//  Reset: all shadow/active enables 0, positions 0, blink counters 0; drawingRequest 0, RGBout 8'h00,
//   offsetX/Y 0, objectIdx 0, activeMask 0. Reset mid-frame takes effect immediately.
//  loadReady = !startOfFrame (combinational). Accepted write updates shadow slot next edge; write to
//   loadIdx >= NUM_OBJECTS is accepted and discarded.
//  Commit: on startOfFrame edge, active <= shadow for all slots; blink counters of blinking slots
//   decrement by 1. Slot whose counter goes 1->0 is disabled in both shadow and active.
//  Hit: hitValid on enabled active slot with counter 0 loads counter = BLINK_FRAMES next edge.
//   Hit on disabled, already-blinking or out-of-range slot ignored. Hit and startOfFrame same
//   cycle: load applies, no decrement that frame. Accepted load write to a slot clears its counter
//   (load wins over same-cycle hit).
//  Visibility: slot visible = active enable && (counter==0 || counter[0]==1) (odd frames shown).
//  Inside test per slot in 12-bit signed: pixelX>=X && pixelX<X+W && pixelY>=Y && pixelY<Y+H.
//  Priority: lowest-index visible slot containing pixel wins.
//  Latency: outputs registered, 1 cycle after pixelX/Y. Hit: drawingRequest 1, RGBout OBJECT_COLOR,
//   offsets = pixel - topLeft (11 bits, non-negative), objectIdx = winner. Miss: drawingRequest 0,
//   RGBout 8'hFF, offsets 0, objectIdx 0.
//  activeMask registered, reflects committed enables (incl. auto-disable) from the commit edge.
// TESTING
//  Load slot0 (100,50,en) + startOfFrame; pixel (100,50) -> next cycle draw=1, off=(0,0), idx=0; (164,50)->draw=0, RGB=FF.
//  Load slot2 (-20,-10,en), commit; pixel (0,0) -> draw=1, off=(20,10); pixel (44,0) -> draw=0.
//  Slots1,3 overlap at (200,200); pixel (210,205) -> idx=1, off=(10,5); disable slot1+commit -> idx=3.
//  Load slot0 new pos with no startOfFrame -> drawing still at old pos until pulse; pulse cycle loadReady=0.
//  BLINK_FRAMES=4, hit slot0: draw on frames with counter 3,1, hidden at 4,2; after 4th commit activeMask[0]=0.
//  Assert resetN mid-line while draw=1 -> outputs drop to reset values same cycle; slots all disabled.

Source files
------------

// File: rtl/obstacle_array_square_object.sv
// Multi-slot square obstacle: NUM_OBJECTS same-size rectangles with frame-atomic position
// commit, blink-then-destroy on hit, and a registered per-pixel draw request / offset output.
module obstacle_array_square_object #(
    parameter int         NUM_OBJECTS     = 4,
    parameter int         OBJECT_WIDTH_X  = 64,
    parameter int         OBJECT_HEIGHT_Y = 64,
    parameter logic [7:0] OBJECT_COLOR    = 8'h5b,
    parameter int         BLINK_FRAMES    = 8
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic signed [10:0]      pixelX,
    input  logic signed [10:0]      pixelY,
    input  logic                    loadValid,
    output logic                    loadReady,
    input  logic [3:0]              loadIdx,
    input  logic signed [10:0]      loadTopLeftX,
    input  logic signed [10:0]      loadTopLeftY,
    input  logic                    loadEnable,
    input  logic                    hitValid,
    input  logic [3:0]              hitIdx,
    output logic [10:0]             offsetX,
    output logic [10:0]             offsetY,
    output logic                    drawingRequest,
    output logic [7:0]              RGBout,
    output logic [3:0]              objectIdx,
    output logic [NUM_OBJECTS-1:0]  activeMask
);

    localparam logic signed [11:0] WIDTH_12  = 12'(OBJECT_WIDTH_X);
    localparam logic signed [11:0] HEIGHT_12 = 12'(OBJECT_HEIGHT_Y);
    localparam logic [7:0]         BLINK_LOAD = 8'(BLINK_FRAMES);

    logic [NUM_OBJECTS-1:0] shadow_en;
    logic [NUM_OBJECTS-1:0] active_en;
    logic signed [10:0]     shadow_x  [NUM_OBJECTS];
    logic signed [10:0]     shadow_y  [NUM_OBJECTS];
    logic signed [10:0]     active_x  [NUM_OBJECTS];
    logic signed [10:0]     active_y  [NUM_OBJECTS];
    logic [7:0]             blink_cnt [NUM_OBJECTS];

    logic [NUM_OBJECTS-1:0] load_sel;
    logic [NUM_OBJECTS-1:0] hit_sel;
    logic [NUM_OBJECTS-1:0] visible;

    logic signed [11:0] px_12;
    logic signed [11:0] py_12;
    logic signed [11:0] cand_left;
    logic signed [11:0] cand_top;
    logic               win_any;
    logic [3:0]         win_idx;
    logic [10:0]        win_off_x;
    logic [10:0]        win_off_y;

    // Writes are refused only during the commit pulse so a commit never sees a half-written slot.
    assign loadReady  = !startOfFrame;
    assign activeMask = active_en;

    // Out-of-range indices match no slot, so those writes and hits fall away naturally.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        load_sel = '0;
        hit_sel  = '0;
        visible  = '0;
        for (int i = 0; i < NUM_OBJECTS; i++) begin
            load_sel[i] = loadValid && !startOfFrame && (loadIdx == 4'(i));
            hit_sel[i]  = hitValid && (hitIdx == 4'(i)) && active_en[i] && (blink_cnt[i] == 8'd0);
            visible[i]  = active_en[i] && ((blink_cnt[i] == 8'd0) || blink_cnt[i][0]);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shadow_en <= '0;
            active_en <= '0;
            // NOTE: the slot arrays are a handful of flops, not RAM, so they take the async reset too.
            for (int i = 0; i < NUM_OBJECTS; i++) begin
                shadow_x[i]  <= '0;
                shadow_y[i]  <= '0;
                active_x[i]  <= '0;
                active_y[i]  <= '0;
                blink_cnt[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let later statements below override earlier ones cleanly.
            for (int i = 0; i < NUM_OBJECTS; i++) begin
                if (startOfFrame) begin
                    active_en[i] <= shadow_en[i];
                    active_x[i]  <= shadow_x[i];
                    active_y[i]  <= shadow_y[i];
                    if (blink_cnt[i] != 8'd0) begin
                        blink_cnt[i] <= blink_cnt[i] - 8'd1;
                        if (blink_cnt[i] == 8'd1) begin
                            shadow_en[i] <= 1'b0;
                            active_en[i] <= 1'b0;
                        end
                    end
                end
                if (hit_sel[i])
                    blink_cnt[i] <= BLINK_LOAD;
                // A fresh load revives the slot: it wins over a same-cycle hit.
                if (load_sel[i]) begin
                    shadow_en[i] <= loadEnable;
                    shadow_x[i]  <= loadTopLeftX;
                    shadow_y[i]  <= loadTopLeftY;
                    blink_cnt[i] <= 8'd0;
                end
            end
        end
    end

    // Inside test runs in 12 bits so X+W cannot wrap for positions near the 11-bit limit.
    assign px_12 = {pixelX[10], pixelX};
    assign py_12 = {pixelY[10], pixelY};

    always_comb begin
        win_any   = 1'b0;
        win_idx   = '0;
        win_off_x = '0;
        win_off_y = '0;
        cand_left = '0;
        cand_top  = '0;
        // Scanning downward leaves the lowest matching index as the winner.
        for (int i = NUM_OBJECTS - 1; i >= 0; i--) begin
            cand_left = {active_x[i][10], active_x[i]};
            cand_top  = {active_y[i][10], active_y[i]};
            if (visible[i] &&
                (px_12 >= cand_left) && (px_12 < cand_left + WIDTH_12) &&
                (py_12 >= cand_top)  && (py_12 < cand_top + HEIGHT_12)) begin
                win_any   = 1'b1;
                win_idx   = 4'(i);
                win_off_x = pixelX - active_x[i];
                win_off_y = pixelY - active_y[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drawingRequest <= 1'b0;
            RGBout         <= 8'h00;
            offsetX        <= '0;
            offsetY        <= '0;
            objectIdx      <= '0;
        end else begin
            drawingRequest <= win_any;
            RGBout         <= win_any ? OBJECT_COLOR : 8'hFF;
            offsetX        <= win_off_x;
            offsetY        <= win_off_y;
            objectIdx      <= win_idx;
        end
    end

endmodule
